// File: rtl/mm_result_streamer.sv
// Walks the 2x2 result of matrix_multiply via sel_out, captures each 17-bit entry
// and streams it LSB-first as three bytes over a valid/ready byte interface.
module mm_result_streamer #(
    parameter int SETTLE_CYCLES = 1    // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [16:0] mm_out,
    output logic [1:0]  sel_out,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_CAPTURE,
        S_SEND
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_index;
    logic [3:0]  r_settle;
    logic [23:0] r_shift;
    logic [1:0]  r_byte_cnt;
    logic [1:0]  r_sel;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_next;
    logic [1:0]  w_index_next;
    logic [3:0]  w_settle_next;
    logic [23:0] w_shift_next;
    logic [1:0]  w_byte_cnt_next;
    logic [1:0]  w_sel_next;
    logic        w_valid_next;
    logic        w_busy_next;
    logic        w_done_next;
    logic        w_accept;

    assign w_accept = r_valid && byte_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_index    <= 2'd0;
            r_settle   <= 4'd0;
            r_shift    <= 24'd0;
            r_byte_cnt <= 2'd0;
            r_sel      <= 2'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_index    <= w_index_next;
            r_settle   <= w_settle_next;
            r_shift    <= w_shift_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_sel      <= w_sel_next;
            r_valid    <= w_valid_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_index_next    = r_index;
        w_settle_next   = r_settle;
        w_shift_next    = r_shift;
        w_byte_cnt_next = r_byte_cnt;
        w_sel_next      = r_sel;
        w_valid_next    = r_valid;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next  = S_SELECT;
                    w_index_next  = 2'd0;
                    w_settle_next = 4'd0;
                    w_sel_next    = 2'd0;
                    w_busy_next   = 1'b1;
                end
            end
            S_SELECT: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_next  = S_CAPTURE;
                    w_settle_next = 4'd0;
                end else begin
                    w_settle_next = r_settle + 4'd1;
                end
            end
            S_CAPTURE: begin
                w_shift_next    = {7'd0, mm_out};
                w_byte_cnt_next = 2'd0;
                w_valid_next    = 1'b1;
                w_state_next    = S_SEND;
            end
            S_SEND: begin
                if (w_accept) begin
                    // Three shifts empty the register, so byte_out idles at zero.
                    w_shift_next    = {8'd0, r_shift[23:8]};
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd2) begin
                        w_valid_next = 1'b0;
                        if (r_index == 2'd3) begin
                            w_state_next = S_IDLE;
                            w_sel_next   = 2'd0;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_index_next  = r_index + 2'd1;
                            w_sel_next    = r_index + 2'd1;
                            w_settle_next = 4'd0;
                            w_state_next  = S_SELECT;
                        end
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign sel_out    = r_sel;
    assign byte_out   = r_shift[7:0];
    assign byte_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
